// File: rtl/step_generator_pkg.sv
// Shared types and field widths for the step generator: motion record layout and FSM states.
package step_generator_pkg;

  localparam int SegmentAxes = 4;
  localparam int AxisIncBits = 16;
  localparam int LoopsBits   = 32;
  localparam int PeriodBits  = 16;

  // Field order is MSB first, so loops lands at bit 0 of the record.
  typedef struct packed {
    logic [SegmentAxes-1:0][AxisIncBits-1:0] inc;
    logic [15-SegmentAxes:0]                 reserved;
    logic [SegmentAxes-1:0]                  dir;
    logic [PeriodBits-1:0]                   tick_period;
    logic [LoopsBits-1:0]                    loops;
  } segment_t;

  typedef enum logic [1:0] {IDLE, DIR_SETUP, RUN} state_t;

endpackage

// File: rtl/step_generator_axis.sv
// One DDA axis: phase accumulator, carry-triggered fixed-width step pulse and, with
// STEP_GENERATOR_POSITION_EN defined, a signed position counter.
module step_axis
  import step_generator_pkg::*;
#(
  parameter int StepPulseCycles = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic [AxisIncBits-1:0] inc,
  input  logic                   dir,
  output logic                   step,
  output logic                   pulse_active
`ifdef STEP_GENERATOR_POSITION_EN
  ,
  output logic [31:0]            position
`endif
);

  localparam int WidthBits = $clog2(StepPulseCycles + 1);

  logic [AxisIncBits-1:0] acc_reg;
  logic [WidthBits-1:0]   width_reg;
  logic                   step_reg;
  logic [AxisIncBits:0]   sum;
  logic                   carry;

  assign sum   = {1'b0, acc_reg} + {1'b0, inc};
  assign carry = tick && sum[AxisIncBits];

  // step_reg is a flop so the pin never sees decode glitches from the width counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg   <= '0;
      width_reg <= '0;
      step_reg  <= 1'b0;
    end else begin
      if (tick) acc_reg <= sum[AxisIncBits-1:0];
      if (carry) begin
        width_reg <= WidthBits'(StepPulseCycles);
        step_reg  <= 1'b1;
      end else begin
        if (width_reg != '0) width_reg <= width_reg - 1'b1;
        step_reg <= (width_reg > WidthBits'(1));
      end
    end
  end

  assign step         = step_reg;
  assign pulse_active = step_reg;

`ifdef STEP_GENERATOR_POSITION_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) position <= '0;
    else if (carry) position <= dir ? position + 32'd1 : position - 32'd1;
  end
`else
  logic unused_dir;
  assign unused_dir = dir;
`endif

endmodule

// File: rtl/step_generator.sv
// Segment sequencer: fetches motion records, waits out direction setup, then ticks the
// per-axis DDAs. Optional position outputs are enabled by STEP_GENERATOR_POSITION_EN.
module step_generator
  import step_generator_pkg::*;
#(
  parameter  int Axes            = SegmentAxes,
  parameter  int StepPulseCycles = 8,
  parameter  int DirSetupCycles  = 16,
  localparam int RecordBits      = 64 + 16 * Axes
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [RecordBits-1:0] fifo_data,
  output logic                  fifo_read_en,
  output logic [Axes-1:0]       step,
  output logic [Axes-1:0]       dir,
  output logic                  busy,
  output logic                  underrun
`ifdef STEP_GENERATOR_POSITION_EN
  ,
  output logic [Axes-1:0][31:0] position
`endif
);

  localparam logic [PeriodBits-1:0] MinPeriod = PeriodBits'(StepPulseCycles + 1);
  localparam logic [15:0]           SetupLast = 16'(DirSetupCycles - 1);

  state_t                          state_reg, state_next;
  logic [Axes-1:0]                 dir_reg;
  logic [Axes-1:0][AxisIncBits-1:0] inc_reg;
  logic [LoopsBits-1:0]            loops_left_reg;
  logic [PeriodBits-1:0]           period_reg;
  logic [PeriodBits-1:0]           tick_cnt_reg;
  logic [15:0]                     setup_cnt_reg;
  logic                            underrun_reg;
  logic [Axes-1:0]                 pulse_active;
  logic                            any_pulse;
  logic                            fetch;
  logic                            tick;
  logic                            unused_reserved;

  logic [LoopsBits-1:0]  rec_loops;
  logic [PeriodBits-1:0] rec_period;
  logic [Axes-1:0]       rec_dir;

  assign rec_loops       = fifo_data[31:0];
  assign rec_period      = fifo_data[47:32];
  assign rec_dir         = fifo_data[48 +: Axes];
  assign unused_reserved = ^fifo_data[63:48];
  assign any_pulse       = |pulse_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    fetch      = 1'b0;
    tick       = 1'b0;
    case (state_reg)
      IDLE: begin
        fetch = enable && !fifo_empty && !any_pulse;
        if (fetch && rec_loops != '0) state_next = DIR_SETUP;
      end
      DIR_SETUP: if (enable && setup_cnt_reg == SetupLast) state_next = RUN;
      RUN: begin
        tick = enable && (tick_cnt_reg == period_reg - 1'b1);
        if (tick && loops_left_reg == LoopsBits'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_reg        <= '0;
      inc_reg        <= '0;
      loops_left_reg <= '0;
      period_reg     <= '0;
      tick_cnt_reg   <= '0;
      setup_cnt_reg  <= '0;
      underrun_reg   <= 1'b0;
    end else begin
      if (fetch) begin
        underrun_reg <= 1'b0;
        // A zero-length record is consumed without touching dir or the DDA state.
        if (rec_loops != '0) begin
          dir_reg        <= rec_dir;
          inc_reg        <= fifo_data[RecordBits-1:64];
          loops_left_reg <= rec_loops;
          period_reg     <= (rec_period < MinPeriod) ? MinPeriod : rec_period;
          setup_cnt_reg  <= '0;
        end
      end
      if (state_reg == DIR_SETUP && enable) begin
        setup_cnt_reg <= setup_cnt_reg + 1'b1;
        if (setup_cnt_reg == SetupLast) tick_cnt_reg <= '0;
      end
      if (state_reg == RUN && enable) begin
        if (tick) begin
          tick_cnt_reg   <= '0;
          loops_left_reg <= loops_left_reg - 1'b1;
          if (loops_left_reg == LoopsBits'(1) && fifo_empty) underrun_reg <= 1'b1;
        end else begin
          tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < Axes; gi++) begin : g_axis
    step_axis #(
      .StepPulseCycles(StepPulseCycles)
    ) u_axis (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .inc         (inc_reg[gi]),
      .dir         (dir_reg[gi]),
      .step        (step[gi]),
      .pulse_active(pulse_active[gi])
`ifdef STEP_GENERATOR_POSITION_EN
      ,
      .position    (position[gi])
`endif
    );
  end

  // Gated by rst so a held reset never drains the FIFO.
  assign fifo_read_en = fetch && !rst;
  assign dir          = dir_reg;
  assign busy         = (state_reg != IDLE) || any_pulse;
  assign underrun     = underrun_reg;

endmodule
